// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: parses SYNC/CNT/data/CHK frames from a byte
// stream, writes big-endian words, and holds the CPU in reset until a frame checks good.
module imem_loader #(
   parameter int         ADDR_W  = 8,
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         TIMEOUT = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR} state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [1:0]          bidx_q, bidx_d;
   logic [7:0]          acc_q, acc_d;
   logic [23:0]         asm_q, asm_d;
   logic [IW-1:0]       idle_q, idle_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                active, timeout_hit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      acc_d   = acc_q;
      asm_d   = asm_q;
      idle_d  = idle_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;

      active      = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
      // Fires on the (TIMEOUT+1)-th silent edge after the last accepted byte.
      timeout_hit = (TIMEOUT != 0) && !byte_valid && (idle_q == IW'(TIMEOUT));

      if (active) begin
         if (byte_valid)
            idle_d = '0;
         else if (!timeout_hit)
            idle_d = idle_q + 1'b1;
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (byte_valid && byte_in == SYNC) begin
               state_d = S_COUNT;
               bidx_d  = '0;
               widx_d  = '0;
               wcnt_d  = '0;
               acc_d   = '0;
               idle_d  = '0;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_COUNT: begin
            if (byte_valid) begin
               cnt_d   = byte_in;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (byte_valid) begin
               asm_d  = {asm_q[15:0], byte_in};
               acc_d  = acc_q ^ byte_in;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = widx_q;
                  wdata_d = {asm_q, byte_in};
                  widx_d  = widx_q + 1'b1;
                  wcnt_d  = wcnt_q + 8'd1;
                  // wcnt counts completed words, so the CNT-th index is the last one.
                  if (wcnt_q == cnt_q)
                     state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (byte_valid) begin
               if (byte_in == acc_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (active && timeout_hit) begin
         state_d = S_ERROR;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         acc_q   <= '0;
         asm_q   <= '0;
         idle_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         acc_q   <= acc_d;
         asm_q   <= asm_d;
         idle_q  <= idle_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold, done, err;

   imem_loader #(.ADDR_W(8), .SYNC(8'hA5), .TIMEOUT(20)) dut (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Write log captured on the falling edge, away from the active edge.
   logic [39:0] wq[$];
   int          wcyc[$];
   int          done_cyc = 0, err_cyc = 0;
   logic        done_prev = 1'b0, err_prev = 1'b0;
   always @(negedge clk) begin
      if (imem_we) begin
         wq.push_back({imem_addr, imem_wdata});
         wcyc.push_back(cyc);
      end
      if (done && !done_prev) done_cyc <= cyc;
      if (err && !err_prev) err_cyc <= cyc;
      done_prev <= done;
      err_prev  <= err;
   end

   logic [7:0]  txq[$];
   int          gapq[$];
   logic [31:0] words[256];
   int          last_cyc;
   int          wbase;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input int gap);
      txq.push_back(b);
      gapq.push_back(gap);
   endtask

   // Frame = SYNC, CNT, words MSB first, XOR of data bytes (optionally corrupted).
   task automatic add_frame(input int n, input int maxgap, input bit corrupt);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      push_byte(8'hA5, $urandom_range(0, maxgap));
      push_byte(8'(n - 1), $urandom_range(0, maxgap));
      for (int i = 0; i < n; i++)
         for (int k = 3; k >= 0; k--) begin
            b = words[i][8*k +: 8];
            x = x ^ b;
            push_byte(b, $urandom_range(0, maxgap));
         end
      if (corrupt) x = x ^ 8'($urandom_range(1, 255));
      push_byte(x, $urandom_range(0, maxgap));
   endtask

   task automatic send_stream();
      for (int i = 0; i < txq.size(); i++) begin
         for (int g = 0; g < gapq[i]; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
         end
         @(negedge clk);
         byte_in    = txq[i];
         byte_valid = 1'b1;
         last_cyc   = cyc;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      txq.delete();
      gapq.delete();
   endtask

   task automatic check_frame(input string tag, input int n, input bit good, input bit b2b);
      repeat (3) @(negedge clk);
      chk({tag, ".nwrites"}, 64'(wq.size() - wbase), 64'(n));
      if (wq.size() - wbase == n) begin
         for (int i = 0; i < n; i++) begin
            chk({tag, ".addr"}, 64'(wq[wbase + i][39:32]), 64'(i % 256));
            chk({tag, ".data"}, 64'(wq[wbase + i][31:0]), 64'(words[i]));
            if (b2b && i > 0)
               chk({tag, ".spacing"}, 64'(wcyc[wbase + i] - wcyc[wbase + i - 1]), 64'd4);
         end
         if (b2b && good)
            chk({tag, ".done_lat"}, 64'(done_cyc - wcyc[wbase + n - 1]), 64'd1);
      end
      chk({tag, ".done"}, 64'(done), 64'(good));
      chk({tag, ".err"}, 64'(err), 64'(!good));
      chk({tag, ".hold"}, 64'(cpu_hold), 64'(!good));
      wbase = wq.size();
   endtask

   initial begin
      int  n;
      bit  good;
      bit  seen;

      wbase = 0;
      repeat (3) @(negedge clk);
      chk("rst.we", 64'(imem_we), 64'd0);
      chk("rst.addr", 64'(imem_addr), 64'd0);
      chk("rst.wdata", 64'(imem_wdata), 64'd0);
      chk("rst.hold", 64'(cpu_hold), 64'd1);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.err", 64'(err), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      words[0] = 32'h12345678;
      add_frame(1, 0, 1'b0);
      send_stream();
      check_frame("single", 1, 1'b1, 1'b1);

      words[0] = 32'hDEADBEEF; words[1] = 32'h00000001; words[2] = 32'h80FF7F10;
      add_frame(3, 0, 1'b0);
      send_stream();
      check_frame("three", 3, 1'b1, 1'b1);

      words[0] = 32'h12345678;
      push_byte(8'hA5, 0); push_byte(8'h00, 0);
      push_byte(8'h12, 0); push_byte(8'h34, 0); push_byte(8'h56, 0); push_byte(8'h78, 0);
      push_byte(8'h09, 0);
      send_stream();
      check_frame("badchk", 1, 1'b0, 1'b1);

      words[0] = 32'hA5A5A5A5;
      push_byte(8'h00, 1); push_byte(8'hFF, 0);
      add_frame(1, 1, 1'b0);
      send_stream();
      check_frame("garbage_sync_data", 1, 1'b1, 1'b0);

      push_byte(8'hA5, 0); push_byte(8'h00, 0); push_byte(8'h11, 0);
      send_stream();
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = err;
      end
      chk("timeout.err_seen", 64'(seen), 64'd1);
      @(negedge clk);
      chk("timeout.latency", 64'(err_cyc - (last_cyc + 1)), 64'd21);
      chk("timeout.nwrites", 64'(wq.size() - wbase), 64'd0);
      chk("timeout.hold", 64'(cpu_hold), 64'd1);
      chk("timeout.done", 64'(done), 64'd0);
      wbase = wq.size();

      push_byte(8'hA5, 0); push_byte(8'h00, 0); push_byte(8'hAA, 0); push_byte(8'hBB, 0);
      send_stream();
      reset = 1'b1;
      @(negedge clk);
      chk("midrst.hold", 64'(cpu_hold), 64'd1);
      chk("midrst.err", 64'(err), 64'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst.nwrites", 64'(wq.size() - wbase), 64'd0);
      wbase = wq.size();
      words[0] = 32'hCAFEF00D; words[1] = 32'h0BADC0DE;
      add_frame(2, 0, 1'b0);
      send_stream();
      check_frame("after_rst", 2, 1'b1, 1'b1);

      for (int f = 0; f < 12; f++) begin
         n    = $urandom_range(1, 6);
         good = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < n; i++) words[i] = $urandom;
         if ($urandom_range(0, 1) == 1) push_byte(8'($urandom_range(0, 164)), 0);
         if (f % 3 == 0) begin
            add_frame(n, 0, !good);
            send_stream();
            check_frame("rand_b2b", n, good, 1'b1);
         end else begin
            add_frame(n, 3, !good);
            send_stream();
            check_frame("rand_gap", n, good, 1'b0);
         end
      end

      for (int i = 0; i < 256; i++) words[i] = $urandom;
      add_frame(256, 0, 1'b0);
      send_stream();
      check_frame("full256", 256, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the single-cycle MIPS instruction memory. It receives a framed byte stream, assembles big-endian 32-bit words and issues one-cycle write strobes to the instruction memory write port. It holds the CPU in reset until a complete frame passes its checksum. It sits between the host byte link (UART receiver or testbench) and the instruction memory; the CPU only reads what this block has written.

## Interface
- ADDR_W, 8: word-address width; matches instruction memory index PC[9:2]; frame holds up to 2^ADDR_W words.
- SYNC, 8'hA5: frame start byte.
- TIMEOUT, 50000: maximum clk cycles between bytes inside a frame; 0 disables the timeout.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- byte_in  in  8  received byte; valid only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe; one byte per strobe; back-to-back strobes allowed.
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  high = keep CPU in reset; drives the CPU's reset_n through an inverter.
- done  out  1  high after a good frame, until the next SYNC or reset.
- err  out  1  high after a bad frame, until the next SYNC or reset.

## Operation
- Frame format: SYNC, then CNT (word count N = CNT+1, range 1..256), then 4N data bytes (MSB first within each word), then CHK = XOR of all 4N data bytes.
- States: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
- IDLE:
  - Non-SYNC bytes are ignored.
  - SYNC goes to COUNT and clears the byte index, word index, XOR accumulator, done and err.
- COUNT: the next byte is latched as CNT, then the state goes to DATA.
- DATA:
  - Each byte shifts into a 32-bit assembly register (shift left by 8, new byte in [7:0]) and XORs into the accumulator.
  - On the 4th byte of a word, the next cycle drives imem_we=1, imem_addr=word index and imem_wdata=assembled word. The word index then increments.
  - After word N is written, the state goes to CHECK.
- CHECK: the next byte is compared with the accumulator.
  - Equal: go to DONE. done=1, cpu_hold=0.
  - Not equal: go to ERROR. err=1, cpu_hold stays 1.
- DONE / ERROR:
  - Non-SYNC bytes are ignored.
  - SYNC restarts the frame: go to COUNT, cpu_hold=1, done=0, err=0.
- Timeout: in COUNT, DATA or CHECK, if TIMEOUT≠0 and TIMEOUT cycles pass with no byte_valid, go to ERROR. The idle counter clears on every accepted byte.
- Words written before an error or timeout remain in memory. No rollback.
- Address wrap: word index is ADDR_W bits. With CNT=255 the last write goes to address 255 and the index is never used past that.
- A SYNC value appearing inside COUNT/DATA/CHECK is treated as data, not as a restart.

## Timing
- Reset values (asynchronous): state IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, all counters and the accumulator 0.
- All outputs are registered; no combinational path from byte_in or byte_valid to any output.
- Write latency: imem_we is high exactly one cycle, in the cycle after the clock edge that accepts the 4th byte of a word. imem_addr and imem_wdata are valid in that same cycle and hold until the next write.
- Back-to-back input: with byte_valid high every cycle, one word is written every 4 cycles. No byte is dropped.
- Completion: done/cpu_hold change in the cycle after the edge that accepts CHK. This is 1 cycle after the last write pulse at the earliest.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial word is discarded and no write pulse is issued.
- Timeout: err rises TIMEOUT+1 cycles after the last accepted byte.

## Test plan
- Reset then good frame A5,00,12,34,56,78,CHK=08 -> one write pulse: addr 0, data 0x12345678; then done=1, err=0, cpu_hold=0.
- Good 3-word frame, byte_valid every cycle -> writes at addr 0,1,2 exactly 4 cycles apart; done=1.
- Bad checksum: same as the first frame with CHK=09 -> addr 0 is written with 0x12345678; err=1, done=0, cpu_hold=1.
- Garbage bytes 00,FF before A5, and A5 used as a data byte inside a frame -> garbage is ignored; the A5 is written as data (e.g. word 0xA5A5A5A5); checksum still passes.
- TIMEOUT=20: send A5,00,11 then stop -> err=1 exactly 21 cycles after byte 11; no write pulse issued.
- Reset asserted after 2 data bytes, then a full good frame -> no stray write; the new frame writes addr 0 correctly; done=1.
